// File: rtl/serial_payload_collector.sv
// rtl/serial_payload_collector.sv - deserialises port address and payload length after a start sequence, steers payload bits to one of 2**ADDR_W ports
module serial_payload_collector #(
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ser_in,
  input  logic                   collect_valid,
  output logic                   detect,
  output logic [ADDR_W-1:0]      port_num,
  output logic                   data_out,
  output logic [2**ADDR_W-1:0]   out_valid,
  output logic [CNT_W-1:0]       cnt_left,
  output logic                   busy
);

  localparam int FLD_MAX = (ADDR_W > CNT_W) ? ADDR_W : CNT_W;
  localparam int BC_W    = $clog2(FLD_MAX + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [BC_W-1:0] ADDR_LAST = BC_W'(ADDR_W - 1);
  localparam logic [BC_W-1:0] LEN_LAST  = BC_W'(CNT_W - 1);

  logic [2:0]       state;
  logic [BC_W-1:0]  bit_cnt;
  logic [CNT_W-1:0] len_next;

  // port_num and cnt_left double as the shift registers while their fields arrive
  assign len_next = CNT_W'({cnt_left, ser_in});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      port_num <= '0;
      cnt_left <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (collect_valid) begin
            state   <= S_ADDR;
            bit_cnt <= '0;
          end
        end
        S_ADDR: begin
          port_num <= ADDR_W'({port_num, ser_in});
          if (bit_cnt == ADDR_LAST) begin
            bit_cnt <= '0;
            state   <= S_LEN;
          end else begin
            bit_cnt <= bit_cnt + BC_W'(1);
          end
        end
        S_LEN: begin
          cnt_left <= len_next;
          if (bit_cnt == LEN_LAST) begin
            bit_cnt <= '0;
            state   <= (len_next == '0) ? S_DONE : S_DATA;
          end else begin
            bit_cnt <= bit_cnt + BC_W'(1);
          end
        end
        S_DATA: begin
          cnt_left <= cnt_left - CNT_W'(1);
          if (cnt_left == CNT_W'(1)) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // decoded from state so an asynchronous reset clears out_valid at once
  always_comb begin
    out_valid = '0;
    if (state == S_DATA) begin
      out_valid[port_num] = 1'b1;
    end
  end

  assign data_out = ser_in;
  assign detect   = (state == S_DONE);
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_serial_payload_collector.sv
// tb/tb_serial_payload_collector.sv - self-checking bench for serial_payload_collector
module tb_serial_payload_collector;
  localparam int A  = 2;
  localparam int C  = 4;
  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ser_in = 1'b0;
  logic          cv_drv = 1'b0;
  logic          use_det = 1'b0;
  logic          collect_valid;
  logic          detect;
  logic [A-1:0]  port_num;
  logic          data_out;
  logic [NP-1:0] out_valid;
  logic [C-1:0]  cnt_left;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int ndet  = 0;

  // behavioural start-sequence detector: hunts for 0111110, waits for detect
  logic [5:0] hist;
  logic       hunting;
  logic       det_cv;

  assign det_cv        = hunting && (hist == 6'b011111) && (ser_in == 1'b0);
  assign collect_valid = use_det ? det_cv : cv_drv;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist    <= '0;
      hunting <= 1'b1;
    end else begin
      if (hunting && !det_cv) hist <= {hist[4:0], ser_in};
      else hist <= '0;
      if (det_cv) hunting <= 1'b0;
      else if (detect) hunting <= 1'b1;
    end
  end

  always #5 clk = ~clk;

  serial_payload_collector #(.ADDR_W(A), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .ser_in(ser_in), .collect_valid(collect_valid),
    .detect(detect), .port_num(port_num), .data_out(data_out),
    .out_valid(out_valid), .cnt_left(cnt_left), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_detect"}, 32'(detect), 32'd0);
    chk({tag, "_port_num"}, 32'(port_num), 32'd0);
    chk({tag, "_cnt_left"}, 32'(cnt_left), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  // i = cycles since the collect_valid cycle for a frame to port addr with len payload bits
  task automatic check_cycle(input int i, input int addr, input int len);
    int fin;
    fin = A + C + len + 1;
    chk("busy", 32'(busy), 32'(i <= fin));
    chk("detect", 32'(detect), 32'(i == fin));
    chk("out_valid", 32'(out_valid), (i > A + C && i < fin) ? 32'(1 << addr) : 32'd0);
    chk("data_out", 32'(data_out), 32'(ser_in));
    if (i > A + C && i <= fin) begin
      chk("port_num", 32'(port_num), 32'(addr));
      chk("cnt_left", 32'(cnt_left), (i == fin) ? 32'd0 : 32'(len - (i - A - C - 1)));
    end
  endtask

  task automatic run_frame(input int addr, input int len, input int pay,
                           input bit inject, input int abort_at);
    bit bits[$];
    int fin;
    fin = A + C + len + 1;
    for (int b = A - 1; b >= 0; b--) bits.push_back(addr[b]);
    for (int b = C - 1; b >= 0; b--) bits.push_back(len[b]);
    for (int b = len - 1; b >= 0; b--) bits.push_back(pay[b]);
    @(posedge clk); #1;
    cv_drv = 1'b1;
    ser_in = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    for (int i = 1; i <= fin + 1; i++) begin
      @(posedge clk); #1;
      cv_drv = inject && (i > A) && (i < fin);
      ser_in = (i <= bits.size()) ? bits[i-1] : 1'($urandom);
      if (i == abort_at) begin
        #2 rst = 1'b0;
        #1 check_reset_outputs("abort");
        @(posedge clk); #1;
        rst = 1'b1;
        cv_drv = 1'b0;
        for (int k = 0; k < 12; k++) begin
          @(posedge clk); #1;
          ser_in = 1'($urandom);
          @(negedge clk);
          chk("post_abort_detect", 32'(detect), 32'd0);
          chk("post_abort_busy", 32'(busy), 32'd0);
        end
        return;
      end
      @(negedge clk);
      check_cycle(i, addr, len);
    end
    cv_drv = 1'b0;
  endtask

  initial begin
    logic [16:0] seg;
    int k, i;

    // reset state, data_out passes ser_in through
    rst = 1'b0;
    ser_in = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
    chk("reset_data_out", 32'(data_out), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    ser_in = 1'b0;

    // T2 reference frame
    run_frame(2, 3, 5, 1'b0, 0);

    // T1: reset mid-frame after address captured, then a normal frame
    @(posedge clk); #1; cv_drv = 1'b1; ser_in = 1'b0;
    @(posedge clk); #1; cv_drv = 1'b0; ser_in = 1'b1;
    @(posedge clk); #1; ser_in = 1'b0;
    @(posedge clk); #1; ser_in = 1'b1;
    #2 rst = 1'b0;
    #1 check_reset_outputs("midreset");
    @(posedge clk); #1; rst = 1'b1;
    run_frame(1, 2, 2, 1'b0, 0);

    // T3 zero length, T4 max length to port 3
    run_frame(1, 0, 0, 1'b0, 0);
    run_frame(3, 15, int'($urandom_range(0, 32767)), 1'b0, 0);

    // T5 spurious collect_valid during LEN and DATA
    run_frame(2, 3, 5, 1'b1, 0);

    // T6 reset in DATA (cycle 8), then a fresh frame
    run_frame(2, 3, 5, 1'b0, 8);
    run_frame(2, 3, 5, 1'b0, 0);

    // randomized frames
    for (int n = 0; n < 12; n++) begin
      run_frame(int'($urandom_range(0, NP - 1)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 32767)), 1'($urandom), 0);
    end

    // T7 with the behavioural start detector, two back-to-back frames
    @(posedge clk); #1; rst = 1'b0; ser_in = 1'b0;
    @(posedge clk); #1; rst = 1'b1; use_det = 1'b1;
    seg = 17'b01111101000111010;
    ndet = 0;
    for (int idx = 0; idx < 36; idx++) begin
      @(posedge clk); #1;
      k = idx % 17;
      ser_in = (idx < 34) ? seg[16 - k] : 1'b0;
      i = (idx < 34 && k >= 7) ? k - 6 : 100;
      @(negedge clk);
      check_cycle(i, 2, 3);
      if (detect) ndet++;
    end
    chk("t7_detect_count", 32'(ndet), 32'd2);
    use_det = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
